// File: rtl/l15_req_arbiter.sv
// Arbitrates the single L1.5 transducer port between the instruction-fetch and data-memory requesters.
// Holds the grant from request issue until the response is consumed, with starvation control on the losing side.
module l15_req_arbiter #(
    parameter int unsigned ADDR_W       = 40,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MEM_PRIORITY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction requester
    input  logic              i_l15_val,
    input  logic [4:0]        i_l15_rqtype,
    input  logic [2:0]        i_l15_size,
    input  logic [ADDR_W-1:0] i_l15_address,
    input  logic [DATA_W-1:0] i_l15_data,
    input  logic              i_l15_req_ack,
    output logic              l15_i_header_ack,
    output logic              l15_i_ack,
    output logic              l15_i_val,
    output logic [DATA_W-1:0] l15_i_data_0,
    output logic [DATA_W-1:0] l15_i_data_1,
    output logic [3:0]        l15_i_returntype,
    // memory requester
    input  logic              m_l15_val,
    input  logic [4:0]        m_l15_rqtype,
    input  logic [2:0]        m_l15_size,
    input  logic [ADDR_W-1:0] m_l15_address,
    input  logic [DATA_W-1:0] m_l15_data,
    input  logic              m_l15_req_ack,
    output logic              l15_m_header_ack,
    output logic              l15_m_ack,
    output logic              l15_m_val,
    output logic [DATA_W-1:0] l15_m_data_0,
    output logic [DATA_W-1:0] l15_m_data_1,
    output logic [3:0]        l15_m_returntype,
    // downstream transducer port
    output logic              transducer_l15_val,
    output logic [4:0]        transducer_l15_rqtype,
    output logic [2:0]        transducer_l15_size,
    output logic [ADDR_W-1:0] transducer_l15_address,
    output logic [DATA_W-1:0] transducer_l15_data,
    output logic              transducer_l15_req_ack,
    input  logic              l15_transducer_ack,
    input  logic              l15_transducer_header_ack,
    input  logic              l15_transducer_val,
    input  logic [DATA_W-1:0] l15_transducer_data_0,
    input  logic [DATA_W-1:0] l15_transducer_data_1,
    input  logic [3:0]        l15_transducer_returntype,
    // status
    output logic              grant_mem,
    output logic              busy
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_owner_mem, w_owner_mem_nxt;
    logic [STREAK_W-1:0]   r_streak, w_streak_nxt;
    logic                  r_tval, w_tval_nxt;
    logic [4:0]            r_rqtype, w_rqtype_nxt;
    logic [2:0]            r_size, w_size_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [DATA_W-1:0]     r_data, w_data_nxt;

    logic w_prio_mem, w_both, w_starved, w_win_mem, w_owner_req_ack;
    logic w_in_req, w_in_resp, w_own_i, w_own_m;

    assign w_prio_mem = (MEM_PRIORITY != 0);
    assign w_both     = i_l15_val && m_l15_val;
    assign w_starved  = (r_streak == STREAK_MAX);
    // A saturated streak hands a contested grant to the non-priority side.
    assign w_win_mem  = w_both ? (w_starved ? !w_prio_mem : w_prio_mem) : m_l15_val;
    assign w_owner_req_ack = r_owner_mem ? m_l15_req_ack : i_l15_req_ack;

    // State and latched request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner_mem <= 1'b0;
            r_streak    <= '0;
            r_tval      <= 1'b0;
            r_rqtype    <= '0;
            r_size      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner_mem <= w_owner_mem_nxt;
            r_streak    <= w_streak_nxt;
            r_tval      <= w_tval_nxt;
            r_rqtype    <= w_rqtype_nxt;
            r_size      <= w_size_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
        end
    end

    // Next-state, grant and streak bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_mem_nxt = r_owner_mem;
        w_streak_nxt    = r_streak;
        w_tval_nxt      = r_tval;
        w_rqtype_nxt    = r_rqtype;
        w_size_nxt      = r_size;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        case (r_state)
            ST_IDLE: begin
                if (i_l15_val || m_l15_val) begin
                    w_state_nxt     = ST_REQ;
                    w_owner_mem_nxt = w_win_mem;
                    w_tval_nxt      = 1'b1;
                    w_rqtype_nxt    = w_win_mem ? m_l15_rqtype  : i_l15_rqtype;
                    w_size_nxt      = w_win_mem ? m_l15_size    : i_l15_size;
                    w_addr_nxt      = w_win_mem ? m_l15_address : i_l15_address;
                    w_data_nxt      = w_win_mem ? m_l15_data    : i_l15_data;
                    if (w_both && (w_win_mem == w_prio_mem))
                        w_streak_nxt = w_starved ? STREAK_MAX : r_streak + STREAK_W'(1);
                    else
                        w_streak_nxt = '0;
                end
            end
            ST_REQ: begin
                if (l15_transducer_header_ack || l15_transducer_ack) begin
                    w_state_nxt = ST_RESP;
                    w_tval_nxt  = 1'b0;
                end
            end
            ST_RESP: begin
                if (l15_transducer_val && w_owner_req_ack)
                    w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tval_nxt  = 1'b0;
            end
        endcase
    end

    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_own_i   = !r_owner_mem;
    assign w_own_m   = r_owner_mem;

    // Handshakes and response data reach the owner only
    assign l15_i_header_ack = w_in_req && w_own_i && l15_transducer_header_ack;
    assign l15_m_header_ack = w_in_req && w_own_m && l15_transducer_header_ack;
    assign l15_i_ack        = w_in_req && w_own_i && l15_transducer_ack;
    assign l15_m_ack        = w_in_req && w_own_m && l15_transducer_ack;
    assign l15_i_val        = w_in_resp && w_own_i && l15_transducer_val;
    assign l15_m_val        = w_in_resp && w_own_m && l15_transducer_val;
    assign l15_i_data_0     = (w_in_resp && w_own_i) ? l15_transducer_data_0 : '0;
    assign l15_i_data_1     = (w_in_resp && w_own_i) ? l15_transducer_data_1 : '0;
    assign l15_i_returntype = (w_in_resp && w_own_i) ? l15_transducer_returntype : '0;
    assign l15_m_data_0     = (w_in_resp && w_own_m) ? l15_transducer_data_0 : '0;
    assign l15_m_data_1     = (w_in_resp && w_own_m) ? l15_transducer_data_1 : '0;
    assign l15_m_returntype = (w_in_resp && w_own_m) ? l15_transducer_returntype : '0;

    assign transducer_l15_val     = r_tval;
    assign transducer_l15_rqtype  = r_rqtype;
    assign transducer_l15_size    = r_size;
    assign transducer_l15_address = r_addr;
    assign transducer_l15_data    = r_data;
    assign transducer_l15_req_ack = w_in_resp && w_owner_req_ack;

    assign busy      = (r_state != ST_IDLE);
    assign grant_mem = busy && r_owner_mem;

endmodule
